// File: rtl/store_merge_unit_pkg.sv
// Purpose: shared size codes, FSM encoding and lane helpers for the store merge path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package store_merge_unit_pkg;

    // Store access width codes, as carried on Req_Size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Highest byte lane index; big-endian lane k maps to LANE_LAST - k.
    localparam logic [1:0] LANE_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Illegal size or an address not naturally aligned to the access width.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Purpose: request + data-memory bundle for the store merge unit.
// Latency: n/a (wiring only).
// Backpressure: Req_Valid/Req_Ready on the request side, Rd/Wr held until Mem_Ack on memory side.
interface store_merge_unit_if #(
    parameter int ADDR_W = 32
);
    logic              Req_Valid;
    logic              Req_Ready;
    logic [ADDR_W-1:0] Req_Addr;
    logic [31:0]       Req_Data;
    logic [1:0]        Req_Size;
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_Rd;
    logic              Mem_Wr;
    logic [31:0]       Mem_WData;
    logic [31:0]       Mem_RData;
    logic              Mem_Ack;
    logic              Done;
    logic              Misaligned;

    // The store merge unit itself.
    modport slave (
        input  Req_Valid, Req_Addr, Req_Data, Req_Size, Mem_RData, Mem_Ack,
        output Req_Ready, Mem_Addr, Mem_Rd, Mem_Wr, Mem_WData, Done, Misaligned
    );

    // Requester plus memory model driving the unit.
    modport master (
        output Req_Valid, Req_Addr, Req_Data, Req_Size, Mem_RData, Mem_Ack,
        input  Req_Ready, Mem_Addr, Mem_Rd, Mem_Wr, Mem_WData, Done, Misaligned
    );

endinterface

// File: rtl/store_merge_unit_lane_merge.sv
// Purpose: places a byte/half/word store value into its lane of an existing memory word.
// Latency: combinational.
// Backpressure: none.
// Ports: old_word (word read from memory), data (register value), addr_lo (byte offset),
//        size (access width code), new_word (merged result).
module store_lane_merge
    import store_merge_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] new_word
);

    logic [1:0] lane;
    logic       half;

    always_comb begin
        new_word = old_word;
        lane     = BIG_ENDIAN ? (LANE_LAST - addr_lo) : addr_lo;
        half     = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
        case (size)
            // Only the low bits of the register survive; the rest of the word is preserved.
            SZ_BYTE: new_word[{lane, 3'b000} +: 8]  = data[7:0];
            SZ_HALF: new_word[{half, 4'b0000} +: 16] = data[15:0];
            default: new_word = data;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Purpose: narrows a register value to sb/sh/sw width and writes it to word-only data memory (RMW for sb/sh).
// Latency: accept-to-Done 2 cycles for sw, 3 for sb/sh with immediate Mem_Ack; Ready back one cycle later.
// Backpressure: one store in flight; Req_Ready low from accept until the FSM returns to IDLE; strobes held until Mem_Ack.
// Ports: Clk/Reset (sync, active-high), bus = request handshake + memory port + Done/Misaligned pulses.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int ADDR_W     = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    store_merge_unit_if.slave bus
);

    state_e            state_q;
    logic              req_ready_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              done_q;
    logic              misaligned_q;

    // Latched request fields needed after accept.
    logic [1:0]        addr_lo_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;

    logic [ADDR_W-1:0] word_addr_d;
    logic              misaligned_d;
    logic [31:0]       merged_d;

    assign word_addr_d  = {bus.Req_Addr[ADDR_W-1:2], 2'b00};
    assign misaligned_d = is_misaligned(bus.Req_Size, bus.Req_Addr[1:0]);

    // Merge against the read data of the Ack cycle; only consumed in READ when Mem_Ack is high.
    store_lane_merge #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_merge (
        .old_word (bus.Mem_RData),
        .data     (data_q),
        .addr_lo  (addr_lo_q),
        .size     (size_q),
        .new_word (merged_d)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            addr_lo_q    <= 2'b00;
            data_q       <= '0;
            size_q       <= SZ_BYTE;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.Req_Valid && req_ready_q) begin
                        addr_lo_q   <= bus.Req_Addr[1:0];
                        data_q      <= bus.Req_Data;
                        size_q      <= bus.Req_Size;
                        req_ready_q <= 1'b0;
                        if (misaligned_d) begin
                            // Rejected: memory port left untouched.
                            state_q      <= ST_ERR;
                            misaligned_q <= 1'b1;
                        end else if (bus.Req_Size == SZ_WORD) begin
                            state_q     <= ST_WRITE;
                            mem_addr_q  <= word_addr_d;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= bus.Req_Data;
                        end else begin
                            state_q    <= ST_READ;
                            mem_addr_q <= word_addr_d;
                            mem_rd_q   <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.Mem_Ack) begin
                        state_q     <= ST_WRITE;
                        mem_rd_q    <= 1'b0;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                    end
                end
                ST_WRITE: begin
                    if (bus.Mem_Ack) begin
                        state_q  <= ST_DONE;
                        mem_wr_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    mem_rd_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Req_Ready  = req_ready_q;
    assign bus.Mem_Addr   = mem_addr_q;
    assign bus.Mem_Rd     = mem_rd_q;
    assign bus.Mem_Wr     = mem_wr_q;
    assign bus.Mem_WData  = mem_wdata_q;
    assign bus.Done       = done_q;
    assign bus.Misaligned = misaligned_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Purpose: self-checking bench for store_merge_unit, little- and big-endian instances side by side.
// Latency: n/a.
// Backpressure: bench plays requester and word-only memory with programmable read stall.
module tb_store_merge_unit;
    import store_merge_unit_pkg::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        sel;        // 0 = little-endian DUT, 1 = big-endian DUT
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    store_merge_unit_if #(.ADDR_W(32)) if_le ();
    store_merge_unit_if #(.ADDR_W(32)) if_be ();

    assign if_le.Req_Valid = req_valid & ~sel;
    assign if_be.Req_Valid = req_valid & sel;
    assign if_le.Req_Addr  = req_addr;
    assign if_be.Req_Addr  = req_addr;
    assign if_le.Req_Data  = req_data;
    assign if_be.Req_Data  = req_data;
    assign if_le.Req_Size  = req_size;
    assign if_be.Req_Size  = req_size;
    assign if_le.Mem_RData = mem_rdata;
    assign if_be.Mem_RData = mem_rdata;
    assign if_le.Mem_Ack   = mem_ack & ~sel;
    assign if_be.Mem_Ack   = mem_ack & sel;

    store_merge_unit #(.BIG_ENDIAN(1'b0), .ADDR_W(32)) dut_le (.Clk(Clk), .Reset(Reset), .bus(if_le));
    store_merge_unit #(.BIG_ENDIAN(1'b1), .ADDR_W(32)) dut_be (.Clk(Clk), .Reset(Reset), .bus(if_be));

    logic        o_ready, o_rd, o_wr, o_done, o_mis;
    logic [31:0] o_maddr, o_wdata;
    assign o_ready = sel ? if_be.Req_Ready  : if_le.Req_Ready;
    assign o_rd    = sel ? if_be.Mem_Rd     : if_le.Mem_Rd;
    assign o_wr    = sel ? if_be.Mem_Wr     : if_le.Mem_Wr;
    assign o_done  = sel ? if_be.Done       : if_le.Done;
    assign o_mis   = sel ? if_be.Misaligned : if_le.Misaligned;
    assign o_maddr = sel ? if_be.Mem_Addr   : if_le.Mem_Addr;
    assign o_wdata = sel ? if_be.Mem_WData  : if_le.Mem_WData;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Observations from the last transaction.
    int          obs_rd_cnt, obs_wr_cnt, obs_done_cnt, obs_mis_cnt;
    int          obs_done_cyc, obs_first_wr_cyc;
    logic        obs_rd_unstable, obs_both;
    logic [31:0] obs_rd_addr, obs_wr_addr, obs_wr_data;
    logic [15:0] obs_ready_hist;

    function automatic logic [31:0] model_merge(input logic be, input logic [31:0] old_w,
                                                input logic [31:0] d, input logic [1:0] a,
                                                input logic [1:0] sz);
        int          sh;
        logic [31:0] m;
        if (sz == SZ_WORD) return d;
        if (sz == SZ_BYTE) begin
            sh = be ? 8 * (3 - int'(a)) : 8 * int'(a);
            m  = 32'hFF << sh;
            return (old_w & ~m) | ((d & 32'hFF) << sh);
        end
        sh = be ? 16 * (1 - int'(a[1])) : 16 * int'(a[1]);
        m  = 32'hFFFF << sh;
        return (old_w & ~m) | ((d & 32'hFFFF) << sh);
    endfunction

    // Drives one request and plays memory for a fixed window; cycle c counts negedges after accept.
    task automatic run_txn(input logic s, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic [31:0] rd, input int stall);
        @(negedge Clk);
        sel = s;
        #1;
        for (int w = 0; w < 10 && !o_ready; w++) @(negedge Clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        @(negedge Clk);
        req_valid = 1'b0;
        req_data  = $urandom;
        req_addr  = $urandom;
        obs_rd_cnt = 0; obs_wr_cnt = 0; obs_done_cnt = 0; obs_mis_cnt = 0;
        obs_done_cyc = 0; obs_first_wr_cyc = 0;
        obs_rd_unstable = 1'b0; obs_both = 1'b0;
        obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0; obs_ready_hist = '0;
        for (int c = 1; c < 15; c++) begin
            obs_ready_hist[c] = o_ready;
            if (o_rd && o_wr) obs_both = 1'b1;
            if (o_done) begin
                obs_done_cnt++;
                if (obs_done_cyc == 0) obs_done_cyc = c;
            end
            if (o_mis) obs_mis_cnt++;
            if (o_rd) begin
                if (obs_rd_cnt == 0) obs_rd_addr = o_maddr;
                else if (o_maddr !== obs_rd_addr) obs_rd_unstable = 1'b1;
                obs_rd_cnt++;
            end
            if (o_wr) begin
                if (obs_wr_cnt == 0) begin
                    obs_wr_addr      = o_maddr;
                    obs_wr_data      = o_wdata;
                    obs_first_wr_cyc = c;
                end
                obs_wr_cnt++;
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (o_rd && obs_rd_cnt > stall) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else if (o_wr) begin
                mem_ack = 1'b1;
            end
            @(negedge Clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; sel = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
        req_addr = '0; req_data = '0; req_size = SZ_WORD; mem_rdata = '0;
        repeat (3) @(negedge Clk);
        checks++; if (if_le.Req_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready_le got=%b exp=1", if_le.Req_Ready); end
        checks++; if (if_be.Req_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready_be got=%b exp=1", if_be.Req_Ready); end
        checks++; if ({if_le.Mem_Rd, if_le.Mem_Wr, if_be.Mem_Rd, if_be.Mem_Wr} !== 4'b0)
            begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {if_le.Mem_Rd, if_le.Mem_Wr, if_be.Mem_Rd, if_be.Mem_Wr}); end
        checks++; if (if_le.Mem_Addr !== 32'h0 || if_be.Mem_Addr !== 32'h0)
            begin failures++; $display("FAIL reset_addr got=%h/%h exp=0", if_le.Mem_Addr, if_be.Mem_Addr); end
        checks++; if (if_le.Mem_WData !== 32'h0 || if_be.Mem_WData !== 32'h0)
            begin failures++; $display("FAIL reset_wdata got=%h/%h exp=0", if_le.Mem_WData, if_be.Mem_WData); end
        checks++; if ({if_le.Done, if_le.Misaligned, if_be.Done, if_be.Misaligned} !== 4'b0)
            begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {if_le.Done, if_le.Misaligned, if_be.Done, if_be.Misaligned}); end
        Reset = 1'b0;
    endtask

    task automatic test_word_store();
        exp_t e;
        exp_q.push_back('{addr: 32'h100, wdata: 32'hDEADBEEF});
        run_txn(1'b0, 32'h100, 32'hDEADBEEF, SZ_WORD, 32'h0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_rd_cnt !== 0) begin failures++; $display("FAIL word_no_read got=%0d exp=0", obs_rd_cnt); end
        checks++; if (obs_wr_addr !== e.addr) begin failures++; $display("FAIL word_addr got=%h exp=%h", obs_wr_addr, e.addr); end
        checks++; if (obs_wr_data !== e.wdata) begin failures++; $display("FAIL word_wdata got=%h exp=%h", obs_wr_data, e.wdata); end
        checks++; if (obs_done_cnt !== 1 || obs_done_cyc !== 2)
            begin failures++; $display("FAIL word_done got=%0d@%0d exp=1@2", obs_done_cnt, obs_done_cyc); end
        checks++; if (obs_ready_hist[3:1] !== 3'b100)
            begin failures++; $display("FAIL word_ready_return got=%b exp=100", obs_ready_hist[3:1]); end
    endtask

    task automatic test_byte_rmw_le();
        exp_t e;
        exp_q.push_back('{addr: 32'h200, wdata: 32'hAB223344});
        run_txn(1'b0, 32'h203, 32'h123456AB, SZ_BYTE, 32'h11223344, 0);
        e = exp_q.pop_front();
        checks++; if (obs_rd_cnt !== 1 || obs_rd_addr !== e.addr)
            begin failures++; $display("FAIL byte_read got=%0d@%h exp=1@%h", obs_rd_cnt, obs_rd_addr, e.addr); end
        checks++; if (obs_wr_addr !== e.addr || obs_wr_data !== e.wdata)
            begin failures++; $display("FAIL byte_write got=%h:%h exp=%h:%h", obs_wr_addr, obs_wr_data, e.addr, e.wdata); end
        checks++; if (obs_done_cnt !== 1 || obs_done_cyc !== 3)
            begin failures++; $display("FAIL byte_done got=%0d@%0d exp=1@3", obs_done_cnt, obs_done_cyc); end
        checks++; if (obs_both !== 1'b0) begin failures++; $display("FAIL byte_rd_wr_overlap got=%b exp=0", obs_both); end
    endtask

    task automatic test_half_rmw_be();
        exp_t e;
        exp_q.push_back('{addr: 32'h300, wdata: 32'h1122CAFE});
        run_txn(1'b1, 32'h302, 32'hFFFFCAFE, SZ_HALF, 32'h11223344, 0);
        e = exp_q.pop_front();
        checks++; if (obs_rd_addr !== e.addr || obs_wr_addr !== e.addr)
            begin failures++; $display("FAIL half_be_addr got=%h/%h exp=%h", obs_rd_addr, obs_wr_addr, e.addr); end
        checks++; if (obs_wr_data !== e.wdata) begin failures++; $display("FAIL half_be_wdata got=%h exp=%h", obs_wr_data, e.wdata); end
        checks++; if (obs_done_cnt !== 1) begin failures++; $display("FAIL half_be_done got=%0d exp=1", obs_done_cnt); end
    endtask

    task automatic test_misaligned();
        logic [31:0] ma [3];
        logic [1:0]  mz [3];
        ma = '{32'h401, 32'h402, 32'h500};
        mz = '{SZ_HALF, SZ_WORD, 2'b11};
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, ma[i], 32'hCAFEF00D, mz[i], 32'h0, 0);
            checks++; if (obs_mis_cnt !== 1) begin failures++; $display("FAIL misaligned_pulse case=%0d got=%0d exp=1", i, obs_mis_cnt); end
            checks++; if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0)
                begin failures++; $display("FAIL misaligned_no_mem case=%0d got rd=%0d wr=%0d exp=0", i, obs_rd_cnt, obs_wr_cnt); end
            checks++; if (obs_done_cnt !== 0) begin failures++; $display("FAIL misaligned_no_done case=%0d got=%0d exp=0", i, obs_done_cnt); end
            checks++; if (obs_ready_hist[2:1] !== 2'b10)
                begin failures++; $display("FAIL misaligned_ready case=%0d got=%b exp=10", i, obs_ready_hist[2:1]); end
        end
    endtask

    task automatic test_ack_stall();
        exp_t e;
        exp_q.push_back('{addr: 32'h600, wdata: model_merge(1'b0, 32'hA1B2C3D4, 32'h0000005A, 2'd1, SZ_BYTE)});
        run_txn(1'b0, 32'h601, 32'h0000005A, SZ_BYTE, 32'hA1B2C3D4, 5);
        e = exp_q.pop_front();
        checks++; if (obs_rd_cnt !== 6 || obs_rd_unstable !== 1'b0)
            begin failures++; $display("FAIL stall_read_hold got=%0d unstable=%b exp=6 unstable=0", obs_rd_cnt, obs_rd_unstable); end
        checks++; if (obs_first_wr_cyc !== 7) begin failures++; $display("FAIL stall_write_cycle got=%0d exp=7", obs_first_wr_cyc); end
        checks++; if (obs_wr_data !== e.wdata) begin failures++; $display("FAIL stall_wdata got=%h exp=%h", obs_wr_data, e.wdata); end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        int   dcnt;
        @(negedge Clk);
        sel = 1'b0; req_valid = 1'b1; req_addr = 32'h700; req_data = 32'h13579BDF; req_size = SZ_WORD;
        mem_ack = 1'b0;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        checks++; if (o_wr !== 1'b1) begin failures++; $display("FAIL rst_write_active got=%b exp=1", o_wr); end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++; if (o_wr !== 1'b0 || o_ready !== 1'b1)
            begin failures++; $display("FAIL rst_mid_write got wr=%b ready=%b exp wr=0 ready=1", o_wr, o_ready); end
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_done || o_wr) dcnt++;
            @(negedge Clk);
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dcnt); end
        exp_q.push_back('{addr: 32'h704, wdata: 32'h2468ACE0});
        run_txn(1'b0, 32'h704, 32'h2468ACE0, SZ_WORD, 32'h0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_wr_data !== e.wdata || obs_wr_addr !== e.addr || obs_done_cnt !== 1)
            begin failures++; $display("FAIL rst_followup got=%h:%h done=%0d exp=%h:%h done=1", obs_wr_addr, obs_wr_data, obs_done_cnt, e.addr, e.wdata); end
    endtask

    task automatic test_random_merge();
        exp_t        e;
        logic        s;
        logic [31:0] a, d, rd;
        logic [1:0]  sz;
        for (int i = 0; i < 24; i++) begin
            s  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            a  = {20'h0, 10'($urandom), 2'b00};
            if (sz == SZ_BYTE) a[1:0] = 2'($urandom);
            if (sz == SZ_HALF) a[1]   = 1'($urandom);
            d  = $urandom;
            rd = $urandom;
            exp_q.push_back('{addr: {a[31:2], 2'b00}, wdata: model_merge(s, rd, d, a[1:0], sz)});
            run_txn(s, a, d, sz, rd, int'($urandom_range(0, 2)));
            e = exp_q.pop_front();
            checks++; if (obs_wr_addr !== e.addr || obs_wr_data !== e.wdata || obs_done_cnt !== 1)
                begin failures++; $display("FAIL random_store i=%0d be=%b sz=%0d got=%h:%h done=%0d exp=%h:%h done=1",
                                           i, s, sz, obs_wr_addr, obs_wr_data, obs_done_cnt, e.addr, e.wdata); end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_rmw_le();
        test_half_rmw_be();
        test_misaligned();
        test_ack_stall();
        test_reset_mid_write();
        test_random_merge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
